// File: rtl/layer_priority_mux.sv
// layer_priority_mux
//   Composites NUM_LAYERS object layers, a splash layer and a background into
//   one pixel per clock. Layer 0 has the highest priority. Each layer can be
//   enabled or made to blink through masks that only change at frame
//   boundaries. A layer pixel equal to TRANSP_COLOR can be keyed out as
//   transparent. Latency is a fixed 2 cycles on every path.
//
// Ports
//   clk, resetN          pixel clock, synchronous active-low reset
//   pixelValid           current inputs belong to a visible pixel
//   startOfFrame         1-cycle pulse on the first clock of each frame
//   isGameMode           0: only splash/background may be shown
//   splashDR, splashRGB  splash request and colour (never keyed)
//   layerDR, layerRGB    per-layer requests; layer i colour at [i*RGB_W +: RGB_W]
//   backgroundRGB        background colour
//   cfgWr                write strobe for cfgEnable/cfgBlink
//   cfgEnable, cfgBlink  new enable / blink masks
//   cfgPending           a written config waits for the next startOfFrame
//   blinkPhase           1 = blinking layers hidden in the current frame
//   RGBOut, RGBOutValid  composited pixel and pixelValid delayed by 2

module layer_priority_mux #(
  parameter int               NUM_LAYERS   = 8,
  parameter int               RGB_W        = 8,
  parameter bit               TRANSP_EN    = 1'b1,
  parameter logic [RGB_W-1:0] TRANSP_COLOR = 8'hFF,
  parameter int               BLINK_FRAMES = 16
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        pixelValid,
  input  logic                        startOfFrame,
  input  logic                        isGameMode,
  input  logic                        splashDR,
  input  logic [RGB_W-1:0]            splashRGB,
  input  logic [NUM_LAYERS-1:0]       layerDR,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            backgroundRGB,
  input  logic                        cfgWr,
  input  logic [NUM_LAYERS-1:0]       cfgEnable,
  input  logic [NUM_LAYERS-1:0]       cfgBlink,
  output logic                        cfgPending,
  output logic                        blinkPhase,
  output logic [RGB_W-1:0]            RGBOut,
  output logic                        RGBOutValid
);

  localparam int               CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [NUM_LAYERS-1:0] act_enable, act_blink;
  logic [NUM_LAYERS-1:0] pend_enable, pend_blink;
  logic [CNT_W-1:0]      frame_cnt;

  logic                  frame_wrap, apply_cfg;
  logic [NUM_LAYERS-1:0] nxt_enable, nxt_blink;
  logic                  nxt_phase;
  logic [NUM_LAYERS-1:0] eff_req;
  logic [RGB_W-1:0]      win_rgb;
  logic                  layer_hit;

  logic             s1_splash_hit, s1_layer_hit, s1_game, s1_valid;
  logic [RGB_W-1:0] s1_splash_rgb, s1_win_rgb, s1_bg;

  // The masks and phase that hold for the frame starting this cycle are
  // used directly, so the pixel on the startOfFrame clock already sees the
  // new frame's configuration and nothing changes later inside the frame.
  assign frame_wrap = startOfFrame && (frame_cnt == CNT_LAST);
  assign apply_cfg  = startOfFrame && cfgPending;
  assign nxt_enable = apply_cfg ? pend_enable : act_enable;
  assign nxt_blink  = apply_cfg ? pend_blink  : act_blink;
  assign nxt_phase  = blinkPhase ^ frame_wrap;

  always_comb begin
    eff_req = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eff_req[i] = layerDR[i] & nxt_enable[i] & ~(nxt_blink[i] & nxt_phase)
                   & ~(TRANSP_EN && (layerRGB[i*RGB_W +: RGB_W] == TRANSP_COLOR));
    end
  end

  // Scanning from the top index down lets the lowest requesting index win.
  always_comb begin
    win_rgb = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff_req[i]) win_rgb = layerRGB[i*RGB_W +: RGB_W];
    end
  end

  assign layer_hit = |eff_req;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      act_enable  <= '1;
      act_blink   <= '0;
      pend_enable <= '0;
      pend_blink  <= '0;
      cfgPending  <= 1'b0;
      frame_cnt   <= '0;
      blinkPhase  <= 1'b0;
    end else begin
      act_enable <= nxt_enable;
      act_blink  <= nxt_blink;
      blinkPhase <= nxt_phase;
      if (startOfFrame) frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
      // A write coinciding with the frame start is kept for the next frame;
      // the frame start consumes only what was pending before it.
      if (cfgWr) begin
        pend_enable <= cfgEnable;
        pend_blink  <= cfgBlink;
        cfgPending  <= 1'b1;
      end else if (startOfFrame) begin
        cfgPending  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      s1_splash_hit <= 1'b0;
      s1_splash_rgb <= '0;
      s1_layer_hit  <= 1'b0;
      s1_win_rgb    <= '0;
      s1_bg         <= '0;
      s1_game       <= 1'b0;
      s1_valid      <= 1'b0;
      RGBOut        <= '0;
      RGBOutValid   <= 1'b0;
    end else begin
      s1_splash_hit <= splashDR;
      s1_splash_rgb <= splashRGB;
      s1_layer_hit  <= layer_hit;
      s1_win_rgb    <= win_rgb;
      s1_bg         <= backgroundRGB;
      s1_game       <= isGameMode;
      s1_valid      <= pixelValid;
      RGBOutValid   <= s1_valid;
      if (s1_splash_hit)     RGBOut <= s1_splash_rgb;
      else if (!s1_game)     RGBOut <= s1_bg;
      else if (s1_layer_hit) RGBOut <= s1_win_rgb;
      else                   RGBOut <= s1_bg;
    end
  end

endmodule

// File: tb/tb_layer_priority_mux.sv
module tb_layer_priority_mux;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        resetN, pixelValid, startOfFrame, isGameMode, splashDR;
  logic [7:0]  splashRGB, layerDR, backgroundRGB, cfgEnable, cfgBlink;
  logic [63:0] layerRGB;
  logic        cfgWr;
  logic        cfgPending, blinkPhase, RGBOutValid;
  logic [7:0]  RGBOut;

  layer_priority_mux #(
    .NUM_LAYERS(8), .RGB_W(8), .TRANSP_EN(1'b1), .TRANSP_COLOR(8'hFF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .resetN(resetN), .pixelValid(pixelValid), .startOfFrame(startOfFrame),
    .isGameMode(isGameMode), .splashDR(splashDR), .splashRGB(splashRGB),
    .layerDR(layerDR), .layerRGB(layerRGB), .backgroundRGB(backgroundRGB),
    .cfgWr(cfgWr), .cfgEnable(cfgEnable), .cfgBlink(cfgBlink),
    .cfgPending(cfgPending), .blinkPhase(blinkPhase),
    .RGBOut(RGBOut), .RGBOutValid(RGBOutValid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_en, m_bl, m_pend_en, m_pend_bl;
  bit         m_pending, m_phase;
  int         m_cnt;
  logic [8:0] m_s1, m_out;   // {valid, rgb}

  typedef struct {
    bit          sp;
    logic [7:0]  sp_rgb;
    bit          game;
    logic [7:0]  dr;
    logic [63:0] rgb;
    logic [7:0]  bg;
    logic [7:0]  exp;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_pixel();
    logic [7:0] en, bl, rgb;
    bit ph;
    en  = (startOfFrame && m_pending) ? m_pend_en : m_en;
    bl  = (startOfFrame && m_pending) ? m_pend_bl : m_bl;
    ph  = (startOfFrame && m_cnt == BF - 1) ? !m_phase : m_phase;
    rgb = backgroundRGB;
    if (splashDR) rgb = splashRGB;
    else if (isGameMode) begin
      for (int i = 0; i < 8; i++) begin
        if (layerDR[i] && en[i] && !(bl[i] && ph) && layerRGB[i*8 +: 8] != 8'hFF) begin
          rgb = layerRGB[i*8 +: 8];
          break;
        end
      end
    end
    return {pixelValid, rgb};
  endfunction

  task automatic step();
    logic [8:0] cur;
    cur = model_pixel();
    @(posedge clk);
    if (!resetN) begin
      m_en = 8'hFF; m_bl = 8'h00; m_pend_en = 8'h00; m_pend_bl = 8'h00;
      m_pending = 0; m_cnt = 0; m_phase = 0; m_s1 = '0; m_out = '0;
    end else begin
      m_out = m_s1;
      m_s1  = cur;
      if (startOfFrame) begin
        if (m_pending) begin m_en = m_pend_en; m_bl = m_pend_bl; end
        m_cnt++;
        if (m_cnt == BF) begin m_cnt = 0; m_phase = !m_phase; end
      end
      if (cfgWr) begin
        m_pend_en = cfgEnable; m_pend_bl = cfgBlink; m_pending = 1;
      end else if (startOfFrame) m_pending = 0;
    end
    #1;
    chk("model_rgb", RGBOut, m_out[7:0]);
    chk("model_valid", {7'd0, RGBOutValid}, {7'd0, m_out[8]});
    chk("model_pending", {7'd0, cfgPending}, {7'd0, m_pending});
    chk("model_phase", {7'd0, blinkPhase}, {7'd0, m_phase});
  endtask

  task automatic idle_inputs();
    pixelValid = 1; startOfFrame = 0; isGameMode = 1; splashDR = 0; splashRGB = 8'h00;
    layerDR = 8'h00; layerRGB = 64'h0; backgroundRGB = 8'h00;
    cfgWr = 0; cfgEnable = 8'hFF; cfgBlink = 8'h00;
  endtask

  task automatic do_reset();
    resetN = 0; step(); step(); resetN = 1;
  endtask

  logic [7:0] exp6[6] = '{8'hAA, 8'hBB, 8'hBB, 8'hAA, 8'hAA, 8'hBB};
  logic [7:0] ph6[6]  = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01};

  initial begin
    vt[0] = '{1'b0, 8'h00, 1'b1, 8'h06, 64'h0000_0000_00E0_1C00, 8'h00, 8'h1C};
    vt[1] = '{1'b1, 8'h03, 1'b1, 8'hFF, 64'h1111_1111_1111_1111, 8'h00, 8'h03};
    vt[2] = '{1'b0, 8'h03, 1'b0, 8'hFF, 64'h1111_1111_1111_1111, 8'h49, 8'h49};
    vt[3] = '{1'b0, 8'h00, 1'b1, 8'h03, 64'h0000_0000_0000_25FF, 8'h12, 8'h25};
    vt[4] = '{1'b0, 8'h00, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h5A, 8'h5A};
    vt[5] = '{1'b0, 8'h00, 1'b1, 8'h00, 64'h8877_6655_4433_2211, 8'h33, 8'h33};
    vt[6] = '{1'b0, 8'h00, 1'b1, 8'hFF, 64'h8877_6655_4433_2211, 8'h33, 8'h11};
    vt[7] = '{1'b0, 8'h00, 1'b1, 8'h80, 64'h4400_0000_0000_0000, 8'h33, 8'h44};
    vt[8] = '{1'b1, 8'hFF, 1'b0, 8'h01, 64'h0000_0000_0000_0077, 8'h33, 8'hFF};

    idle_inputs();
    do_reset();
    chk("reset_rgb", RGBOut, 8'h00);
    chk("reset_valid", {7'd0, RGBOutValid}, 8'h00);
    chk("reset_pending", {7'd0, cfgPending}, 8'h00);
    chk("reset_phase", {7'd0, blinkPhase}, 8'h00);

    // exact 2-cycle latency
    step(); step();
    layerDR = 8'h06; layerRGB = 64'h0000_0000_00E0_1C00;
    step();
    chk("lat_edge1", RGBOut, 8'h00);
    layerDR = 8'h00; backgroundRGB = 8'h77; pixelValid = 0;
    step();
    chk("lat_edge2", RGBOut, 8'h1C);
    chk("lat_valid2", {7'd0, RGBOutValid}, 8'h01);
    step();
    chk("lat_edge3", RGBOut, 8'h77);
    chk("lat_valid3", {7'd0, RGBOutValid}, 8'h00);

    // table-driven compositing vectors
    for (int k = 0; k < 9; k++) begin
      pixelValid = 1; splashDR = vt[k].sp; splashRGB = vt[k].sp_rgb; isGameMode = vt[k].game;
      layerDR = vt[k].dr; layerRGB = vt[k].rgb; backgroundRGB = vt[k].bg;
      step(); step(); step();
      chk($sformatf("vec%0d", k), RGBOut, vt[k].exp);
    end

    // mid-frame config is held until the frame start
    idle_inputs();
    layerDR = 8'h03; layerRGB = 64'h0000_0000_0000_BBAA; backgroundRGB = 8'h10;
    cfgWr = 1; cfgEnable = 8'hFE; step(); cfgWr = 0;
    step(); step();
    chk("cfg_pending_set", {7'd0, cfgPending}, 8'h01);
    chk("cfg_old_mask", RGBOut, 8'hAA);
    startOfFrame = 1; step(); startOfFrame = 0;
    step(); step();
    chk("cfg_new_mask", RGBOut, 8'hBB);
    chk("cfg_pending_clr", {7'd0, cfgPending}, 8'h00);

    // write coincident with frame start
    cfgWr = 1; cfgEnable = 8'hF0; step();
    startOfFrame = 1; cfgEnable = 8'h0F; step();
    cfgWr = 0; startOfFrame = 0;
    layerDR = 8'hFF; layerRGB = 64'h8877_6655_4433_2211;
    step(); step();
    chk("coinc_active_f0", RGBOut, 8'h55);
    chk("coinc_still_pending", {7'd0, cfgPending}, 8'h01);
    startOfFrame = 1; step(); startOfFrame = 0;
    step(); step();
    chk("coinc_active_0f", RGBOut, 8'h11);
    chk("coinc_pending_clr", {7'd0, cfgPending}, 8'h00);

    // blinking layer 0, two frames per half-period
    idle_inputs();
    do_reset();
    layerDR = 8'h03; layerRGB = 64'h0000_0000_0000_BBAA;
    cfgWr = 1; cfgBlink = 8'h01; step(); cfgWr = 0;
    for (int f = 0; f < 6; f++) begin
      startOfFrame = 1; step(); startOfFrame = 0;
      step(); step(); step();
      chk($sformatf("blink_f%0d", f), RGBOut, exp6[f]);
      chk($sformatf("blink_ph%0d", f), {7'd0, blinkPhase}, ph6[f]);
    end

    // reset mid-frame restores masks and flushes the pipe
    cfgWr = 1; cfgEnable = 8'hFE; cfgBlink = 8'h00; step(); cfgWr = 0;
    startOfFrame = 1; step(); startOfFrame = 0;
    step(); step();
    chk("pre_reset_mask", RGBOut, 8'hBB);
    resetN = 0; step(); resetN = 1;
    chk("midrst_rgb", RGBOut, 8'h00);
    chk("midrst_phase", {7'd0, blinkPhase}, 8'h00);
    chk("midrst_pending", {7'd0, cfgPending}, 8'h00);
    step();
    chk("midrst_flush", RGBOut, 8'h00);
    step();
    chk("midrst_mask_reset", RGBOut, 8'hAA);

    // randomized stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      resetN        = ($urandom_range(0, 499) != 0);
      pixelValid    = 1'($urandom);
      startOfFrame  = ($urandom_range(0, 19) == 0);
      isGameMode    = ($urandom_range(0, 7) != 0);
      splashDR      = ($urandom_range(0, 5) == 0);
      splashRGB     = 8'($urandom);
      layerDR       = 8'($urandom);
      for (int i = 0; i < 8; i++)
        layerRGB[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      backgroundRGB = 8'($urandom);
      cfgWr         = ($urandom_range(0, 14) == 0);
      cfgEnable     = 8'($urandom);
      cfgBlink      = 8'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
